imem_refill_ctrl: RTL and testbench



---
 rtl/imem_refill_if.sv | 38 +++
 rtl/imem_refill_ctrl.sv | 107 ++++++++++
 tb/tb_imem_refill_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/imem_refill_if.sv
// imem_refill_if
// Bundles the miss-side handshake and the memory-side read bus of the
// instruction-memory refill engine.
//   miss_req, miss_addr         : core -> refill engine (miss request)
//   word_ready, word_out,
//   word_idx, refill_done, busy : refill engine -> core (refill results)
//   mem_re, mem_addr            : refill engine -> RAM (read strobe/address)
//   mem_rdata                   : RAM -> refill engine (data, one cycle later)
// Modport "slave" is the refill engine's view; "master" is the view of the
// environment (core plus backing RAM).
interface imem_refill_if #(
    parameter int WORD_W     = 32,
    parameter int ADDR_W     = 10,
    parameter int LINE_WORDS = 4
);
    localparam int IDX_W = $clog2(LINE_WORDS);

    logic              miss_req;
    logic [ADDR_W-1:0] miss_addr;
    logic              word_ready;
    logic [WORD_W-1:0] word_out;
    logic [IDX_W-1:0]  word_idx;
    logic              refill_done;
    logic              busy;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_rdata;

    modport slave (
        input  miss_req, miss_addr, mem_rdata,
        output word_ready, word_out, word_idx, refill_done, busy, mem_re, mem_addr
    );

    modport master (
        output miss_req, miss_addr, mem_rdata,
        input  word_ready, word_out, word_idx, refill_done, busy, mem_re, mem_addr
    );
endinterface

// File: rtl/imem_refill_ctrl.sv
// imem_refill_ctrl
// Refills one instruction-cache line from a synchronous-read RAM after a miss.
// Supports configurable line length, wait states before every read,
// optional critical-word-first ordering (wrapping inside the line), abort on
// miss_req falling, and a completion flag held until the miss is released.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : imem_refill_if.slave (miss handshake, refill results, RAM read bus)
module imem_refill_ctrl #(
    parameter int WORD_W      = 32,
    parameter int ADDR_W      = 10,
    parameter int LINE_WORDS  = 4,
    parameter int WAIT_CYCLES = 0,
    parameter int CWF         = 0
) (
    input  logic         clk,
    input  logic         rst,
    imem_refill_if.slave bus
);
    localparam int         IDX_W     = $clog2(LINE_WORDS);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);
    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {IDLE, WAIT, REQ, RESP, DONE} state_t;

    state_t                   state;
    // Line base is kept without its low index bits so that the read address
    // is a plain concatenation and can never carry out of the line.
    logic [ADDR_W-IDX_W-1:0]  line;
    logic [IDX_W-1:0]         offset;
    logic [IDX_W-1:0]         beat;
    logic [3:0]               wait_cnt;

    // Main FSM: accepts a miss, paces reads through optional wait states,
    // captures each returned word and flags completion. word_ready is a
    // one-cycle strobe, so it defaults low every cycle. Every non-idle state
    // abandons the refill as soon as miss_req drops (except DONE, which just
    // returns to IDLE), and a RESP cycle without miss_req captures nothing.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            line           <= '0;
            offset         <= '0;
            beat           <= '0;
            wait_cnt       <= '0;
            bus.word_ready <= 1'b0;
            bus.word_out   <= '0;
            bus.word_idx   <= '0;
        end else begin
            bus.word_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.miss_req) begin
                        line     <= bus.miss_addr[ADDR_W-1:IDX_W];
                        offset   <= (CWF != 0) ? bus.miss_addr[IDX_W-1:0] : '0;
                        beat     <= '0;
                        wait_cnt <= WAIT_LOAD;
                        if (WAIT_CYCLES == 0) state <= REQ;
                        else                  state <= WAIT;
                    end
                end
                WAIT: begin
                    if (!bus.miss_req) begin
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                        if (wait_cnt == 4'd1) state <= REQ;
                    end
                end
                REQ: begin
                    if (!bus.miss_req) state <= IDLE;
                    else               state <= RESP;
                end
                RESP: begin
                    if (!bus.miss_req) begin
                        state <= IDLE;
                    end else begin
                        bus.word_out   <= bus.mem_rdata;
                        bus.word_idx   <= offset;
                        bus.word_ready <= 1'b1;
                        // Offset is IDX_W bits wide, so the increment wraps
                        // inside the line for critical-word-first order.
                        offset         <= offset + 1'b1;
                        beat           <= beat + 1'b1;
                        wait_cnt       <= WAIT_LOAD;
                        if (beat == LAST_BEAT)     state <= DONE;
                        else if (WAIT_CYCLES == 0) state <= REQ;
                        else                       state <= WAIT;
                    end
                end
                DONE: begin
                    if (!bus.miss_req) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read strobe, address and status are decoded straight from the state
    // register; mem_addr is forced to zero outside REQ so it is quiet on
    // the RAM bus and zero out of reset.
    assign bus.mem_re      = (state == REQ);
    assign bus.mem_addr    = (state == REQ) ? {line, offset} : '0;
    assign bus.busy        = (state != IDLE);
    assign bus.refill_done = (state == DONE);
endmodule

// File: tb/tb_imem_refill_ctrl.sv
// tb_imem_refill_ctrl
// Directed bench for imem_refill_ctrl. Three instances share clock, reset
// and the miss request: default ordering, critical-word-first, and three
// wait states. Each has its own RAM model holding mem[a] = a + 0x100.
// Ports exercised: clk, rst and every signal of imem_refill_if.
module tb_imem_refill_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       miss_req;
    logic [9:0] miss_addr;

    int checkCount = 0;
    int errorCount = 0;

    imem_refill_if #(.WORD_W(32), .ADDR_W(10), .LINE_WORDS(4)) bus0 ();
    imem_refill_if #(.WORD_W(32), .ADDR_W(10), .LINE_WORDS(4)) bus1 ();
    imem_refill_if #(.WORD_W(32), .ADDR_W(10), .LINE_WORDS(4)) bus2 ();

    imem_refill_ctrl #(.WORD_W(32), .ADDR_W(10), .LINE_WORDS(4), .WAIT_CYCLES(0), .CWF(0))
        dut_plain (.clk(clk), .rst(rst), .bus(bus0));
    imem_refill_ctrl #(.WORD_W(32), .ADDR_W(10), .LINE_WORDS(4), .WAIT_CYCLES(0), .CWF(1))
        dut_cwf (.clk(clk), .rst(rst), .bus(bus1));
    imem_refill_ctrl #(.WORD_W(32), .ADDR_W(10), .LINE_WORDS(4), .WAIT_CYCLES(3), .CWF(0))
        dut_wait (.clk(clk), .rst(rst), .bus(bus2));

    always #5 clk = ~clk;

    // Shared miss request for all three engines.
    assign bus0.miss_req  = miss_req;
    assign bus1.miss_req  = miss_req;
    assign bus2.miss_req  = miss_req;
    assign bus0.miss_addr = miss_addr;
    assign bus1.miss_addr = miss_addr;
    assign bus2.miss_addr = miss_addr;

    // Synchronous-read RAM models: data appears the cycle after mem_re.
    always_ff @(posedge clk) begin
        if (bus0.mem_re) bus0.mem_rdata <= {22'b0, bus0.mem_addr} + 32'h100;
        if (bus1.mem_re) bus1.mem_rdata <= {22'b0, bus1.mem_addr} + 32'h100;
        if (bus2.mem_re) bus2.mem_rdata <= {22'b0, bus2.mem_addr} + 32'h100;
    end

    // Observation arrays so the per-cycle checks can loop over instances.
    logic        obsRdy  [3];
    logic        obsRe   [3];
    logic        obsDone [3];
    logic        obsBusy [3];
    logic [31:0] obsWord [3];
    logic [1:0]  obsIdx  [3];
    logic [9:0]  obsAddr [3];

    assign obsRdy[0]  = bus0.word_ready;   assign obsRdy[1]  = bus1.word_ready;   assign obsRdy[2]  = bus2.word_ready;
    assign obsRe[0]   = bus0.mem_re;       assign obsRe[1]   = bus1.mem_re;       assign obsRe[2]   = bus2.mem_re;
    assign obsDone[0] = bus0.refill_done;  assign obsDone[1] = bus1.refill_done;  assign obsDone[2] = bus2.refill_done;
    assign obsBusy[0] = bus0.busy;         assign obsBusy[1] = bus1.busy;         assign obsBusy[2] = bus2.busy;
    assign obsWord[0] = bus0.word_out;     assign obsWord[1] = bus1.word_out;     assign obsWord[2] = bus2.word_out;
    assign obsIdx[0]  = bus0.word_idx;     assign obsIdx[1]  = bus1.word_idx;     assign obsIdx[2]  = bus2.word_idx;
    assign obsAddr[0] = bus0.mem_addr;     assign obsAddr[1] = bus1.mem_addr;     assign obsAddr[2] = bus2.mem_addr;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive the miss request; called mid-cycle (after a falling edge).
    task automatic applyStimulus(input logic req, input logic [9:0] addr);
        miss_req  = req;
        miss_addr = addr;
    endtask

    // Advance to the middle of the next cycle.
    task automatic stepCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Expected behaviour of every instance in cycle c after acceptance,
    // with miss_req held high. Beat k: mem_re in k*P+W+1, word_ready in
    // (k+1)*P+1, refill_done from 4*P+1, where P = W+2. base is the line
    // base word address, startOff the low bits of the miss address.
    task automatic checkCycle(input int c, input int base, input int startOff);
        for (int i = 0; i < 3; i++) begin
            int w;
            int p;
            int k;
            int off;
            logic expRe;
            logic expRdy;
            w = (i == 2) ? 3 : 0;
            p = w + 2;
            expRe  = (c >= w + 1) && ((c - w - 1) % p == 0) && ((c - w - 1) / p < 4);
            expRdy = (c >= p + 1) && ((c - p - 1) % p == 0) && ((c - p - 1) / p < 4);
            checkOutput($sformatf("i%0d c%0d mem_re", i, c), 32'(obsRe[i]), 32'(expRe));
            checkOutput($sformatf("i%0d c%0d word_ready", i, c), 32'(obsRdy[i]), 32'(expRdy));
            checkOutput($sformatf("i%0d c%0d refill_done", i, c), 32'(obsDone[i]), 32'(c >= 4 * p + 1));
            checkOutput($sformatf("i%0d c%0d busy", i, c), 32'(obsBusy[i]), 32'd1);
            if (expRe) begin
                k   = (c - w - 1) / p;
                off = (i == 1) ? ((startOff + k) % 4) : k;
                checkOutput($sformatf("i%0d c%0d mem_addr", i, c), 32'(obsAddr[i]), 32'(base + off));
            end
            if (expRdy) begin
                k   = (c - p - 1) / p;
                off = (i == 1) ? ((startOff + k) % 4) : k;
                checkOutput($sformatf("i%0d c%0d word_out", i, c), obsWord[i], 32'(base + 32'h100 + off));
                checkOutput($sformatf("i%0d c%0d word_idx", i, c), 32'(obsIdx[i]), 32'(off));
            end
        end
    endtask

    // All outputs of every instance at their reset values.
    task automatic checkResetState(input string phase);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("%s i%0d word_ready", phase, i), 32'(obsRdy[i]), 32'd0);
            checkOutput($sformatf("%s i%0d word_out", phase, i), obsWord[i], 32'd0);
            checkOutput($sformatf("%s i%0d word_idx", phase, i), 32'(obsIdx[i]), 32'd0);
            checkOutput($sformatf("%s i%0d refill_done", phase, i), 32'(obsDone[i]), 32'd0);
            checkOutput($sformatf("%s i%0d busy", phase, i), 32'(obsBusy[i]), 32'd0);
            checkOutput($sformatf("%s i%0d mem_re", phase, i), 32'(obsRe[i]), 32'd0);
            checkOutput($sformatf("%s i%0d mem_addr", phase, i), 32'(obsAddr[i]), 32'd0);
        end
    endtask

    // Release the miss and confirm every engine returns to idle next cycle.
    task automatic releaseMiss(input string phase);
        applyStimulus(1'b0, 10'h000);
        stepCycle();
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("%s i%0d busy", phase, i), 32'(obsBusy[i]), 32'd0);
            checkOutput($sformatf("%s i%0d refill_done", phase, i), 32'(obsDone[i]), 32'd0);
        end
    endtask

    initial begin
        int strobes;
        rst = 1'b1;
        applyStimulus(1'b0, 10'h000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkResetState("reset");
        rst = 1'b0;
        stepCycle();

        // Full refill of line 0x004 from miss 0x006, held 16 cycles in DONE.
        $display("[TB] basic refill, miss at 0x006");
        applyStimulus(1'b1, 10'h006);
        for (int c = 1; c <= 25; c++) begin
            stepCycle();
            checkCycle(c, 32'h004, 2);
        end
        releaseMiss("basic release");

        // Abort after the second strobe of the default instance.
        $display("[TB] abort after second beat");
        applyStimulus(1'b1, 10'h006);
        for (int c = 1; c <= 5; c++) begin
            stepCycle();
            checkCycle(c, 32'h004, 2);
        end
        applyStimulus(1'b0, 10'h006);
        for (int c = 6; c <= 12; c++) begin
            stepCycle();
            checkOutput($sformatf("abort c%0d mem_re", c), 32'(obsRe[0]), 32'd0);
            checkOutput($sformatf("abort c%0d word_ready", c), 32'(obsRdy[0]), 32'd0);
            checkOutput($sformatf("abort c%0d refill_done", c), 32'(obsDone[0]), 32'd0);
            checkOutput($sformatf("abort c%0d busy", c), 32'(obsBusy[0]), 32'd0);
        end

        // Top line of the store: no carry out of the line.
        $display("[TB] top line, miss at 0x3FE");
        applyStimulus(1'b1, 10'h3FE);
        for (int c = 1; c <= 22; c++) begin
            stepCycle();
            checkCycle(c, 32'h3FC, 2);
        end
        releaseMiss("top release");

        // Reset in cycle 4 of a burst, then a fresh acceptance with miss held.
        $display("[TB] reset mid-burst");
        applyStimulus(1'b1, 10'h006);
        for (int c = 1; c <= 4; c++) begin
            stepCycle();
            checkCycle(c, 32'h004, 2);
        end
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
        checkResetState("midreset");
        strobes = 0;
        for (int c = 1; c <= 24; c++) begin
            stepCycle();
            checkCycle(c, 32'h004, 2);
            if (obsRdy[0]) strobes++;
        end
        checkOutput("strobe count after reset", 32'(strobes), 32'd4);
        releaseMiss("reset release");

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end
endmodule
